// File: rtl/response_timer_pkg.sv
// Shared definitions for the reaction-time measurement block: state encoding
// and counter width, reused by the trial controller and scoring logic.
package response_timer_pkg;

  localparam int CNT_W_DEFAULT = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_PAUSED = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  function automatic logic is_busy(input logic [1:0] st);
    return (st == ST_RUN) || (st == ST_PAUSED);
  endfunction

endpackage

// File: rtl/response_timer.sv
// Counts 100 ms ticks against a per-trial limit and reports either an in-time
// answer (with elapsed ticks) or expiry. All outputs are registered.
module response_timer
  import response_timer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_in,
  input  logic             start,
  input  logic [CNT_W-1:0] duration,
  input  logic             pause,
  input  logic             abort,
  input  logic             answer,
  output logic             busy,
  output logic [CNT_W-1:0] remaining,
  output logic [CNT_W-1:0] elapsed,
  output logic             expired,
  output logic             answered,
  output logic [1:0]       state
);

  logic [1:0]       state_nx;
  logic [CNT_W-1:0] remaining_nx;
  logic [CNT_W-1:0] elapsed_nx;
  logic             expired_nx;
  logic             answered_nx;

  // Priority is abort > start > answer > tick; a zero-length trial expires at once.
  always_comb begin
    state_nx     = state;
    remaining_nx = remaining;
    elapsed_nx   = elapsed;
    expired_nx   = 1'b0;
    answered_nx  = 1'b0;

    if (abort) begin
      state_nx = ST_IDLE;
    end else if (start) begin
      remaining_nx = duration;
      elapsed_nx   = '0;
      if (duration == '0) begin
        state_nx   = ST_DONE;
        expired_nx = 1'b1;
      end else begin
        state_nx = ST_RUN;
      end
    end else begin
      case (state)
        ST_RUN: begin
          if (answer) begin
            answered_nx = 1'b1;
            state_nx    = ST_DONE;
          end else if (pause) begin
            state_nx = ST_PAUSED;
          end else if (tick_in) begin
            elapsed_nx = (&elapsed) ? elapsed : elapsed + 1'b1;
            if (remaining <= CNT_W'(1)) begin
              remaining_nx = '0;
              expired_nx   = 1'b1;
              state_nx     = ST_DONE;
            end else begin
              remaining_nx = remaining - 1'b1;
            end
          end
        end
        ST_PAUSED: begin
          if (!pause) state_nx = ST_RUN;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      remaining <= '0;
      elapsed   <= '0;
      expired   <= 1'b0;
      answered  <= 1'b0;
    end else begin
      state     <= state_nx;
      busy      <= is_busy(state_nx);
      remaining <= remaining_nx;
      elapsed   <= elapsed_nx;
      expired   <= expired_nx;
      answered  <= answered_nx;
    end
  end

endmodule
